instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Upstream stage of the combinational `instruction` execute unit: fetches 16-bit words from program memory,
//  reads two operands from an internal 16x16 register file, drives RA/RB/ins/ZNC into the execute unit,
//  then writes RA_OUT/RB_OUT and ZNC_out back. Multi-cycle, non-pipelined: one instruction in flight.
//  Instruction word: [15:13] opcode (execute stage only), [12] HALT, [11:8] ra_idx, [7:4] rb_idx, [3:0] unused.
// PARAMETERS
//  PC_W    8   program counter width; imem depth 2**PC_W words
//  DATA_W  16  datapath width; fixed at 16 to match the execute unit
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  start         in   1       1-cycle pulse; starts execution at PC=start_pc (IDLE/HALTED only)
//  start_pc      in   PC_W    initial PC, sampled with start
//  imem_req      out  1       fetch request; held high until imem_valid
//  imem_addr     out  PC_W    fetch address (=pc), stable while imem_req high
//  imem_valid    in   1       fetch data valid; any latency >= 1 cycle after req
//  imem_data     in   16      instruction word, sampled when imem_req&imem_valid
//  exe_ra        out  16      operand A = reg[ra_idx]
//  exe_rb        out  16      operand B = reg[rb_idx]
//  exe_ins       out  16      latched instruction word
//  exe_znc_in    out  3       current flag register {Z,N,C}
//  exe_znc_mid   out  3       flag register value before the previous writeback
//  exe_ra_out    in   16      execute result for ra_idx
//  exe_rb_out    in   16      execute result for rb_idx
//  exe_znc_out   in   3       execute flags
//  busy          out  1       high in any state except IDLE/HALTED
//  halted        out  1       high in HALTED
//  pc            out  PC_W    current program counter
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=0, all regs=0, flags=0, flags_prev=0, ins latch=0,
//    imem_req=0, busy=0, halted=0. Exe outputs follow from these zeroed registers.
//  FSM: IDLE -start-> FETCH; FETCH -imem_valid-> DECODE; DECODE -> (HALT bit ? HALTED : EXEC);
//    EXEC -> WB; WB -> FETCH; HALTED -start-> FETCH.
//  FETCH: imem_req=1, imem_addr=pc; on imem_valid, latch imem_data into ins. imem_valid outside FETCH ignored.
//  DECODE: register-file read (sync read) of ra_idx/rb_idx into operand latches.
//  EXEC: exe_* stable for one full cycle; combinational execute settles.
//  WB: reg[ra_idx]<=exe_ra_out, reg[rb_idx]<=exe_rb_out; if ra_idx==rb_idx, exe_ra_out wins;
//    flags_prev<=flags; flags<=exe_znc_out; pc<=pc+1 (wraps 2**PC_W-1 -> 0, no flag).
//  HALT: no register/flag write, pc unchanged (points at HALT word); halted=1.
//  Latency per instruction: 4 cycles + imem wait (FETCH 1+wait, DECODE, EXEC, WB).
//  start while busy: ignored. start in the same cycle as reset release: ignored.
//  exe_* outputs change only on DECODE->EXEC edge; held constant through EXEC and WB.
//  Reset mid-instruction: immediate return to IDLE; partial WB never occurs (WB is a single edge).
// STRUCTURE
//  Shared package: state encoding (IDLE,FETCH,DECODE,EXEC,WB,HALTED),
//    instruction field bit positions (OPC_HI/LO, HALT_BIT, RA_HI/LO, RB_HI/LO).
//  Sub-module: reg_file16 (16x16, 2 sync read ports, 2 write ports, port A priority on address clash).
//  Top: FSM, pc, ins latch, flag/flag_prev registers, imem handshake.
// TESTING
//  1 reset then start, start_pc=0x10, imem returns 0x0120 after 3 wait cycles -> imem_addr=0x10,
//    exe_ins=0x0120 in EXEC, reg1<=exe_ra_out, reg2<=exe_rb_out, pc=0x11, busy throughout.
//  2 word 0x0330 (ra==rb==3), exe_ra_out=0xAAAA, exe_rb_out=0x5555 -> reg3=0xAAAA.
//  3 word 0x1000 (HALT) -> halted=1 after DECODE, pc unchanged, no reg/flag change;
//    start with start_pc=0 -> resumes FETCH at 0.
//  4 start_pc=0xFF, non-HALT word -> after WB pc=0x00, next imem_addr=0x00.
//  5 two instructions, exe_znc_out=3'b100 then 3'b011 -> flags=011, exe_znc_mid=100 on third EXEC.
//  6 rst_n low during EXEC -> IDLE within same cycle, imem_req=0, regs/flags zero; start pulse while busy ignored.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared types and instruction field layout
// for the instruction sequencer.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_t;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 13;
  localparam int HALT_BIT = 12;
  localparam int RA_HI    = 11;
  localparam int RA_LO    = 8;
  localparam int RB_HI    = 7;
  localparam int RB_LO    = 4;

  function automatic logic [3:0] ra_of(
    input logic [15:0] w
  );
    return w[RA_HI:RA_LO];
  endfunction

  function automatic logic [3:0] rb_of(
    input logic [15:0] w
  );
    return w[RB_HI:RB_LO];
  endfunction

endpackage

// File: rtl/reg_file16.sv
// 16x16 register file: two registered read
// ports, two write ports, port A wins a clash.
module reg_file16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [3:0]  rd_a_idx,
  input  logic [3:0]  rd_b_idx,
  output logic [15:0] rd_a,
  output logic [15:0] rd_b,
  input  logic        we,
  input  logic [3:0]  wr_a_idx,
  input  logic [3:0]  wr_b_idx,
  input  logic [15:0] wr_a,
  input  logic [15:0] wr_b
);

  logic [15:0] mem [16];

  // storage; A written last so it overrides B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_b_idx] <= wr_b;
      mem[wr_a_idx] <= wr_a;
    end
  end

  // synchronous read into operand latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else if (rd_en) begin
      rd_a <= mem[rd_a_idx];
      rd_b <= mem[rd_b_idx];
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/writeback sequencer feeding a
// combinational execute unit, one instr in flight.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PC_W-1:0]   start_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] exe_ra,
  output logic [DATA_W-1:0] exe_rb,
  output logic [DATA_W-1:0] exe_ins,
  output logic [2:0]        exe_znc_in,
  output logic [2:0]        exe_znc_mid,
  input  logic [DATA_W-1:0] exe_ra_out,
  input  logic [DATA_W-1:0] exe_rb_out,
  input  logic [2:0]        exe_znc_out,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  state_t            state;
  state_t            nxt;
  logic              armed;
  logic [DATA_W-1:0] ins;
  logic [2:0]        flags;
  logic [2:0]        flags_prev;
  logic              start_ok;
  logic              dec_go;
  logic              wb_go;

  assign start_ok = start & armed;
  assign dec_go   = (state == S_DECODE)
                  & ~ins[HALT_BIT];
  assign wb_go    = (state == S_WB);

  // armed blocks a start coinciding with reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // next state and handshake outputs
  always_comb begin
    nxt      = state;
    imem_req = 1'b0;
    busy     = 1'b1;
    halted   = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ok) nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) nxt = S_DECODE;
      end
      S_DECODE: begin
        nxt = ins[HALT_BIT] ? S_HALTED : S_EXEC;
      end
      S_EXEC: nxt = S_WB;
      S_WB:   nxt = S_FETCH;
      S_HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start_ok) nxt = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign imem_addr = pc;

  // pc load on start, advance on writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (start_ok && !busy) begin
      pc <= start_pc;
    end else if (wb_go) begin
      pc <= pc + 1'b1;
    end
  end

  // instruction latch and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins        <= '0;
      flags      <= '0;
      flags_prev <= '0;
    end else begin
      if (state == S_FETCH && imem_valid) begin
        ins <= imem_data;
      end
      if (wb_go) begin
        flags_prev <= flags;
        flags      <= exe_znc_out;
      end
    end
  end

  // exe-side latches move only on DECODE->EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_ins     <= '0;
      exe_znc_in  <= '0;
      exe_znc_mid <= '0;
    end else if (dec_go) begin
      exe_ins     <= ins;
      exe_znc_in  <= flags;
      exe_znc_mid <= flags_prev;
    end
  end

  reg_file16 u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (dec_go),
    .rd_a_idx (ra_of(ins)),
    .rd_b_idx (rb_of(ins)),
    .rd_a     (exe_ra),
    .rd_b     (exe_rb),
    .we       (wb_go),
    .wr_a_idx (ra_of(ins)),
    .wr_b_idx (rb_of(ins)),
    .wr_a     (exe_ra_out),
    .wr_b     (exe_rb_out)
  );

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with
// hand-computed expectations.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [15:0] exe_ra;
  logic [15:0] exe_rb;
  logic [15:0] exe_ins;
  logic [2:0]  exe_znc_in;
  logic [2:0]  exe_znc_mid;
  logic [15:0] exe_ra_out;
  logic [15:0] exe_rb_out;
  logic [2:0]  exe_znc_out;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_pc    (start_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .exe_ra      (exe_ra),
    .exe_rb      (exe_rb),
    .exe_ins     (exe_ins),
    .exe_znc_in  (exe_znc_in),
    .exe_znc_mid (exe_znc_mid),
    .exe_ra_out  (exe_ra_out),
    .exe_rb_out  (exe_rb_out),
    .exe_znc_out (exe_znc_out),
    .busy        (busy),
    .halted      (halted),
    .pc          (pc)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%h exp=%h",
                tag, obs, exp);
  endtask

  // wait for req, stall, then return word;
  // leaves the bench at the DECODE negedge
  task automatic fetch(
    input string       tag,
    input logic [7:0]  addr,
    input logic [15:0] word,
    input int          waits
  );
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, imem_req, 1);
    chk({tag, "_addr"}, imem_addr, addr);
    repeat (waits) begin
      @(negedge clk);
      chk({tag, "_reqhold"}, imem_req, 1);
    end
    imem_valid = 1'b1;
    imem_data  = word;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 16'hdead;
  endtask

  // drive execute results in EXEC, run to FETCH
  task automatic wb(
    input logic [15:0] ra_o,
    input logic [15:0] rb_o,
    input logic [2:0]  znc_o
  );
    exe_ra_out  = ra_o;
    exe_rb_out  = rb_o;
    exe_znc_out = znc_o;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [7:0] spc);
    start    = 1'b1;
    start_pc = spc;
    @(negedge clk);
    start    = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    start_pc    = '0;
    imem_valid  = 1'b0;
    imem_data   = '0;
    exe_ra_out  = '0;
    exe_rb_out  = '0;
    exe_znc_out = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ins", exe_ins, 0);
    chk("rst_ra", exe_ra, 0);
    chk("rst_znc", exe_znc_in, 0);

    // start together with reset release
    rst_n = 1'b1;
    pulse_start(8'h05);
    chk("relstart_busy", busy, 0);
    chk("relstart_pc", pc, 0);

    // 1: first instruction with 3 stall cycles
    pulse_start(8'h10);
    chk("t1_busy_fetch", busy, 1);
    fetch("t1", 8'h10, 16'h0120, 3);
    chk("t1_busy_dec", busy, 1);
    @(negedge clk);
    chk("t1_ins", exe_ins, 16'h0120);
    chk("t1_ra", exe_ra, 0);
    chk("t1_busy_exec", busy, 1);
    exe_ra_out  = 16'h1111;
    exe_rb_out  = 16'h2222;
    exe_znc_out = 3'b100;
    @(negedge clk);
    chk("t1_busy_wb", busy, 1);
    chk("t1_ins_wb", exe_ins, 16'h0120);
    @(negedge clk);
    chk("t1_pc", pc, 8'h11);

    // 2: ra==rb clash, A wins
    fetch("t2", 8'h11, 16'h0330, 0);
    @(negedge clk);
    chk("t2_ra", exe_ra, 0);
    chk("t2_zin", exe_znc_in, 3'b100);
    chk("t2_zmid", exe_znc_mid, 3'b000);
    wb(16'haaaa, 16'h5555, 3'b011);
    chk("t2_pc", pc, 8'h12);

    // read back reg3/reg1; start while busy
    fetch("t3", 8'h12, 16'h0310, 1);
    @(negedge clk);
    chk("t3_ra_r3", exe_ra, 16'haaaa);
    chk("t3_rb_r1", exe_rb, 16'h1111);
    chk("t3_zin", exe_znc_in, 3'b011);
    chk("t3_zmid", exe_znc_mid, 3'b100);
    exe_ra_out  = 16'h3333;
    exe_rb_out  = 16'h1234;
    exe_znc_out = 3'b001;
    pulse_start(8'h40);
    @(negedge clk);
    chk("busy_start_pc", pc, 8'h13);

    fetch("t4r", 8'h13, 16'h0200, 0);
    @(negedge clk);
    chk("r2", exe_ra, 16'h2222);
    chk("r0", exe_rb, 16'h0000);
    wb(16'h2222, 16'h0000, 3'b010);

    // 3: HALT
    fetch("halt", 8'h14, 16'h1000, 2);
    @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, 8'h14);
    chk("halt_ins", exe_ins, 16'h0200);
    chk("halt_zin", exe_znc_in, 3'b001);
    repeat (3) @(negedge clk);
    chk("halt_stay", halted, 1);
    chk("halt_req", imem_req, 0);

    pulse_start(8'h00);
    chk("resume_halted", halted, 0);
    fetch("resume", 8'h00, 16'h0310, 0);
    @(negedge clk);
    chk("resume_r3", exe_ra, 16'h3333);
    chk("resume_r1", exe_rb, 16'h1234);
    chk("resume_zin", exe_znc_in, 3'b010);
    chk("resume_zmid", exe_znc_mid, 3'b001);
    wb(16'h7777, 16'h8888, 3'b101);
    chk("resume_pc", pc, 8'h01);

    // 4: pc wrap
    fetch("halt2", 8'h01, 16'h1000, 0);
    @(negedge clk);
    chk("halt2", halted, 1);
    pulse_start(8'hff);
    fetch("wrap", 8'hff, 16'h0400, 0);
    @(negedge clk);
    wb(16'h9999, 16'h4444, 3'b110);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_addr", imem_addr, 8'h00);

    // 6: reset during EXEC
    fetch("pre_rst", 8'h00, 16'h0120, 0);
    @(negedge clk);
    chk("pre_rst_r1", exe_ra, 16'h8888);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_ra", exe_ra, 0);
    chk("mid_rst_ins", exe_ins, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(8'h20);
    fetch("post_rst", 8'h20, 16'h0120, 0);
    @(negedge clk);
    chk("post_rst_r1", exe_ra, 0);
    chk("post_rst_r2", exe_rb, 0);
    chk("post_rst_zin", exe_znc_in, 0);
    chk("post_rst_zmid", exe_znc_mid, 0);

    $display("%0d/%0d checks passed",
             passed, total);
    $finish;
  end

endmodule
